// File: rtl/bus_resp_pkg.sv
// -----------------------------------------------------------------------------
// bus_resp_pkg
// Shared definitions for the bus responder slice:
//   bus_resp_state_t  - access state machine states
//   WAIT_W            - width of the wait-state counter (WAIT_STATES 0..15)
//   DEFAULT_IRQ_ADDR  - default doorbell word address
// -----------------------------------------------------------------------------
package bus_resp_pkg;

   localparam int WAIT_W = 4;

   localparam logic [15:0] DEFAULT_IRQ_ADDR = 16'hFFFE;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_ACK  = 3'd3,
      ST_HOLD = 3'd4
   } bus_resp_state_t;

endpackage

// File: rtl/bus_resp_ram.sv
// -----------------------------------------------------------------------------
// bus_resp_ram
// Single-port synchronous word RAM (DEPTH x 16). One access per cycle: the
// addressed word is always read into rdData on the rising edge (read-first),
// and written as well when wrEn is high. Contents are not reset.
// Ports:
//   Clock   in   system clock
//   wrEn    in   write enable for this cycle
//   addr    in   word address (shared by read and write)
//   wrData  in   write data
//   rdData  out  registered read data
// -----------------------------------------------------------------------------
module bus_resp_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clock,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wrData,
   output logic [15:0]       rdData
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge Clock) begin
      if (wrEn) begin
         mem[addr] <= wrData;
      end
      rdData <= mem[addr];
   end

endmodule

// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
// Memory-side responder for the CPU's multiplexed external bus. Latches a
// word address on ALE, decodes nME/nOE/nWE, stretches each access with
// WAIT_STATES cycles of nWait low, then returns read data on DataIn or
// commits the DataOut word to a small on-chip RAM.
//
// Optional feature: define BUS_RESP_IRQ_EN to enable an interrupt doorbell
// at IRQ_ADDR (bit0 of a write sets/clears the pending bit, nIrq = ~pending,
// reads return {15'b0, pending}). Without the macro nIrq is tied high and
// IRQ_ADDR is an ordinary address.
//
// Ports:
//   Clock    in   system clock, rising edge
//   nReset   in   synchronous active-low reset
//   DataOut  in   CPU bus: address while ALE=1, write data otherwise
//   ALE      in   address latch enable
//   nME      in   memory enable (active low)
//   nOE      in   read strobe (active low)
//   nWE      in   write strobe (active low)
//   DataIn   out  registered read data to the CPU
//   nWait    out  registered wait request (active low)
//   nIrq     out  registered interrupt request (active low)
// -----------------------------------------------------------------------------
module bus_responder
   import bus_resp_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          WAIT_STATES = 2,
   parameter logic [15:0] IRQ_ADDR    = DEFAULT_IRQ_ADDR
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [15:0] DataOut,
   input  logic        ALE,
   input  logic        nME,
   input  logic        nOE,
   input  logic        nWE,
   output logic [15:0] DataIn,
   output logic        nWait,
   output logic        nIrq
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

`ifdef BUS_RESP_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   bus_resp_state_t   stateReg;
   logic [15:0]       addrReg;
   logic [WAIT_W-1:0] cntReg;
   logic              isReadReg;
   logic              pendingReg;

   logic              latchAddr;
   logic              accessReq;
   logic              hitIrq;
   logic              hitRam;
   logic              commitWrite;
   logic              ramWrEn;
   logic [ADDR_W-1:0] ramAddr;
   logic [15:0]       ramRdData;
   logic [15:0]       readWord;

   assign latchAddr = ALE && (stateReg == ST_IDLE || stateReg == ST_ADDR);
   assign accessReq = !nME && (!nOE || !nWE);

   // Doorbell wins over the RAM window; with the feature off this folds to 0.
   assign hitIrq = IRQ_EN && (addrReg == IRQ_ADDR);
   // BASE_ADDR is DEPTH-aligned, so the window test is an upper-bits match.
   assign hitRam = !hitIrq && (addrReg[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);

   // Writes commit on the edge leaving ACK; a read with nWE also low is a
   // plain read because isReadReg was captured from nOE at access start.
   assign commitWrite = (stateReg == ST_ACK) && !isReadReg;
   assign ramWrEn     = nReset && commitWrite && hitRam;

   // The RAM port follows the address as it is being latched, so the word is
   // already sitting in ramRdData by the time the access is decoded. This is
   // what lets a zero-wait-state read present data on the very next cycle.
   assign ramAddr = latchAddr ? DataOut[ADDR_W-1:0] : addrReg[ADDR_W-1:0];

   bus_resp_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) ram (
      .Clock  (Clock),
      .wrEn   (ramWrEn),
      .addr   (ramAddr),
      .wrData (DataOut),
      .rdData (ramRdData)
   );

   always_comb begin
      readWord = 16'h0000;
      if (hitIrq) begin
         readWord = {15'b0, pendingReg};
      end else if (hitRam) begin
         readWord = ramRdData;
      end
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         stateReg  <= ST_IDLE;
         addrReg   <= 16'h0000;
         cntReg    <= '0;
         isReadReg <= 1'b0;
         DataIn    <= 16'h0000;
         nWait     <= 1'b1;
      end else begin
         unique case (stateReg)
            ST_IDLE: begin
               if (ALE) begin
                  addrReg  <= DataOut;
                  stateReg <= ST_ADDR;
               end
            end

            ST_ADDR: begin
               if (ALE) begin
                  addrReg <= DataOut;
               end else if (accessReq) begin
                  cntReg    <= WAIT_LOAD;
                  isReadReg <= !nOE;
                  if (WAIT_STATES == 0) begin
                     stateReg <= ST_ACK;
                     if (!nOE) begin
                        DataIn <= readWord;
                     end
                  end else begin
                     stateReg <= ST_WAIT;
                     nWait    <= 1'b0;
                  end
               end
            end

            ST_WAIT: begin
               // Abort takes priority over the final wait cycle.
               if (nME) begin
                  stateReg <= ST_IDLE;
                  nWait    <= 1'b1;
               end else if (cntReg == WAIT_W'(1)) begin
                  stateReg <= ST_ACK;
                  nWait    <= 1'b1;
                  if (isReadReg) begin
                     DataIn <= readWord;
                  end
               end else begin
                  cntReg <= cntReg - WAIT_W'(1);
               end
            end

            ST_ACK: begin
               stateReg <= ST_HOLD;
            end

            ST_HOLD: begin
               if (nME) begin
                  DataIn   <= 16'h0000;
                  stateReg <= ST_IDLE;
               end
            end

            default: begin
               stateReg <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BUS_RESP_IRQ_EN
   always_ff @(posedge Clock) begin
      if (!nReset) begin
         pendingReg <= 1'b0;
         nIrq       <= 1'b1;
      end else if (commitWrite && hitIrq) begin
         pendingReg <= DataOut[0];
         nIrq       <= ~DataOut[0];
      end
   end
`else
   assign pendingReg = 1'b0;
   assign nIrq       = 1'b1;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
// Two responders (WAIT_STATES=2 and WAIT_STATES=0) share one bus master.
// Each access fills per-cycle expectation tables from the timing rules
// (edge N = first edge sampling nME low after the address cycle), and a
// single compare loop checks every DUT output on every falling edge.
// Literal checks pin key values of the model.
// -----------------------------------------------------------------------------
module tb_bus_responder;
   import bus_resp_pkg::*;

   localparam int MAXC = 1024;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        nReset;
   logic [15:0] DataOut;
   logic        ALE, nME, nOE, nWE;
   logic [15:0] dataInA, dataInB;
   logic        nWaitA, nWaitB, nIrqA, nIrqB;

   bus_responder #(
      .DEPTH(256), .BASE_ADDR(16'h0000), .WAIT_STATES(2), .IRQ_ADDR(16'hFFFE)
   ) dutA (
      .Clock(Clock), .nReset(nReset), .DataOut(DataOut), .ALE(ALE),
      .nME(nME), .nOE(nOE), .nWE(nWE),
      .DataIn(dataInA), .nWait(nWaitA), .nIrq(nIrqA)
   );

   bus_responder #(
      .DEPTH(256), .BASE_ADDR(16'h0000), .WAIT_STATES(0), .IRQ_ADDR(16'hFFFE)
   ) dutB (
      .Clock(Clock), .nReset(nReset), .DataOut(DataOut), .ALE(ALE),
      .nME(nME), .nOE(nOE), .nWE(nWE),
      .DataIn(dataInB), .nWait(nWaitB), .nIrq(nIrqB)
   );

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [15:0] expData [2][MAXC];
   logic        expWait [2][MAXC];
   logic        expIrq  [2][MAXC];
   logic [15:0] memModel[2][256];
   logic        pend    [2];
   int          lowCnt  [2];

   logic [15:0] oA, oB;
   int          lA, lB;

   task automatic check(input string name, input int at,
                        input logic [15:0] act, input logic [15:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, at, act, exp);
      end
   endtask

   function automatic int wsOf(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [15:0] modelRead(input int d, input logic [15:0] addr);
`ifdef BUS_RESP_IRQ_EN
      if (addr == 16'hFFFE) return {15'b0, pend[d]};
`endif
      if (addr < 16'd256) return memModel[d][addr[7:0]];
      return 16'h0000;
   endfunction

   task automatic modelWrite(input int d, input logic [15:0] addr,
                             input logic [15:0] data, input int ce);
`ifdef BUS_RESP_IRQ_EN
      if (addr == 16'hFFFE) begin
         pend[d] = data[0];
         for (int e = ce; e < MAXC; e++) expIrq[d][e] = ~data[0];
      end else
`endif
      if (addr < 16'd256) begin
         memModel[d][addr[7:0]] = data;
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   // One bus access: ALE cycle, then nME low for lowLen edges, then idle
   // until both responders are back in IDLE plus one spare edge.
   task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wdata, input int lowLen,
                         output logic [15:0] obsA, output logic [15:0] obsB,
                         output int lowA, output int lowB);
      int n, a, w, endE, maxEnd, lowA0, lowB0;
      logic [15:0] rv;
      n      = cyc + 2;
      a      = n + lowLen;
      maxEnd = a;
      obsA   = 16'hxxxx;
      obsB   = 16'hxxxx;
      for (int d = 0; d < 2; d++) begin
         w = wsOf(d);
         if (a <= n + w) begin
            for (int e = n; e < a; e++) expWait[d][e] = 1'b0;
         end else begin
            for (int e = n; e < n + w; e++) expWait[d][e] = 1'b0;
            endE = (a > n + w + 2) ? a : n + w + 2;
            if (endE > maxEnd) maxEnd = endE;
            if (rd) begin
               rv = modelRead(d, addr);
               for (int e = n + w; e < endE; e++) expData[d][e] = rv;
            end else if (wr) begin
               modelWrite(d, addr, wdata, n + w + 1);
            end
         end
      end
      lowA0 = lowCnt[0];
      lowB0 = lowCnt[1];
      ALE = 1'b1; DataOut = addr; nME = 1'b1; nOE = 1'b1; nWE = 1'b1;
      tick();
      ALE = 1'b0; DataOut = wdata;
      while (cyc < maxEnd + 1) begin
         nME = (cyc + 1 < a) ? 1'b0 : 1'b1;
         nOE = nME | !rd;
         nWE = nME | !wr;
         tick();
         if (cyc == n)     obsB = dataInB;
         if (cyc == n + 2) obsA = dataInA;
      end
      DataOut = 16'h0000;
      lowA = lowCnt[0] - lowA0;
      lowB = lowCnt[1] - lowB0;
      $display("access addr=%h rd=%0b wr=%0b wdata=%h lowLen=%0d -> A:%h/%0d B:%h/%0d",
               addr, rd, wr, wdata, lowLen, obsA, lowA, obsB, lowB);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int e = 0; e < MAXC; e++) begin
            expData[d][e] = 16'h0000;
            expWait[d][e] = 1'b1;
            expIrq[d][e]  = 1'b1;
         end
         for (int i = 0; i < 256; i++) memModel[d][i] = 16'h0000;
         pend[d]   = 1'b0;
         lowCnt[d] = 0;
      end
      nReset = 1'b0; ALE = 1'b0; DataOut = 16'h0000;
      nME = 1'b1; nOE = 1'b1; nWE = 1'b1;

      fork
         forever begin
            @(negedge Clock);
            if (cyc >= 1 && cyc < MAXC) begin
               for (int d = 0; d < 2; d++) begin
                  logic [15:0] actD;
                  logic        actW, actI;
                  actD = (d == 0) ? dataInA : dataInB;
                  actW = (d == 0) ? nWaitA  : nWaitB;
                  actI = (d == 0) ? nIrqA   : nIrqB;
                  if (actW == 1'b0) lowCnt[d]++;
                  check(d == 0 ? "DataIn[W2]" : "DataIn[W0]", cyc, actD, expData[d][cyc]);
                  check(d == 0 ? "nWait[W2]"  : "nWait[W0]",  cyc, 16'(actW), 16'(expWait[d][cyc]));
                  check(d == 0 ? "nIrq[W2]"   : "nIrq[W0]",   cyc, 16'(actI), 16'(expIrq[d][cyc]));
               end
            end
         end
      join_none

      // Reset held for two edges.
      tick(); tick();
      check("reset DataIn", cyc, dataInA, 16'h0000);
      check("reset nWait", cyc, 16'(nWaitA), 16'h0001);
      check("reset nIrq", cyc, 16'(nIrqA), 16'h0001);
      check("reset state", cyc, 16'(dutA.stateReg), 16'(ST_IDLE));
      nReset = 1'b1;
      tick();

      access(16'h0000, 1'b0, 1'b1, 16'h1357, 5, oA, oB, lA, lB);
      access(16'h0010, 1'b0, 1'b1, 16'hA5A5, 5, oA, oB, lA, lB);
      check("write wait cycles W2", cyc, 16'(lA), 16'd2);
      check("write wait cycles W0", cyc, 16'(lB), 16'd0);

      access(16'h0010, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("read 0010 ACK W2", cyc, oA, 16'hA5A5);
      check("read 0010 next cycle W0", cyc, oB, 16'hA5A5);
      check("read wait cycles W2", cyc, 16'(lA), 16'd2);
      check("read wait cycles W0", cyc, 16'(lB), 16'd0);
      check("DataIn after nME rise", cyc, dataInA, 16'h0000);

      access(16'h0100, 1'b0, 1'b1, 16'h1234, 5, oA, oB, lA, lB);
      check("oor write wait cycles", cyc, 16'(lA), 16'd2);
      access(16'h0100, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("oor read W2", cyc, oA, 16'h0000);
      check("oor read W0", cyc, oB, 16'h0000);
      check("oor read wait cycles", cyc, 16'(lA), 16'd2);
      access(16'h0000, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("read 0000 unchanged", cyc, oA, 16'h1357);

      access(16'h0020, 1'b0, 1'b1, 16'h7777, 5, oA, oB, lA, lB);
      access(16'h0020, 1'b0, 1'b1, 16'hBEEF, 1, oA, oB, lA, lB);
      check("abort wait cycles W2", cyc, 16'(lA), 16'd1);
      access(16'h0020, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("aborted write dropped W2", cyc, oA, 16'h7777);
      check("short access commits W0", cyc, oB, 16'hBEEF);

      access(16'h0010, 1'b1, 1'b1, 16'hFFFF, 5, oA, oB, lA, lB);
      check("oe+we reads W2", cyc, oA, 16'hA5A5);
      access(16'h0010, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("oe+we no write W2", cyc, oA, 16'hA5A5);

      access(16'hFFFE, 1'b0, 1'b1, 16'h0001, 5, oA, oB, lA, lB);
`ifdef BUS_RESP_IRQ_EN
      check("doorbell set nIrq W2", cyc, 16'(nIrqA), 16'h0000);
      check("doorbell set nIrq W0", cyc, 16'(nIrqB), 16'h0000);
      access(16'hFFFE, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("doorbell read", cyc, oA, 16'h0001);
      access(16'hFFFE, 1'b0, 1'b1, 16'h0000, 5, oA, oB, lA, lB);
      check("doorbell clear nIrq", cyc, 16'(nIrqA), 16'h0001);
`else
      check("nIrq tied high", cyc, 16'(nIrqA), 16'h0001);
      access(16'hFFFE, 1'b1, 1'b0, 16'h0000, 5, oA, oB, lA, lB);
      check("FFFE plain oor read", cyc, oA, 16'h0000);
`endif

      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
